// File: rtl/onewire_byte_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onewire_byte_engine
// Description : Dallas 1-Wire bit/byte timing engine. Executes bus reset with
//               presence detect, byte write and byte read (LSB first) on one
//               open-drain pin. 1 us timing is derived from the system clock
//               through an internal prescaler that runs only while busy.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_10MHZ  in     system clock
//   rst        in     asynchronous active-high reset (releases the bus at once)
//   dWire      inout  1-Wire bus, driven 0 or released (Z), external pull-up
//   reset      in     command: bus reset + presence detect
//   write_byte in     command: transmit in_byte
//   read_byte  in     command: receive into out_byte
//   read_bit   in     command: single read slot (ONEWIRE_READ_BIT_EN only)
//   in_byte    in     byte to transmit, captured at command accept
//   out_byte   out    last received byte
//   busy       out    operation in progress
//   presense   out    result of last reset, 1 = device answered
// Build option
//   ONEWIRE_READ_BIT_EN : adds read_bit, one slot whose sample lands in
//                         out_byte[0] with out_byte[7:1] cleared.
// ============================================================================
module onewire_byte_engine #(
  parameter int CLK_DIV = 10,
  parameter int T_RSTL  = 480,
  parameter int T_PDS   = 70,
  parameter int T_RSTH  = 480,
  parameter int T_LOW1  = 6,
  parameter int T_LOW0  = 60,
  parameter int T_RDS   = 15,
  parameter int T_SLOT  = 70
) (
  input  logic       CLK_10MHZ,
  input  logic       rst,
  inout  wire        dWire,
  input  logic       reset,
  input  logic       write_byte,
  input  logic       read_byte,
`ifdef ONEWIRE_READ_BIT_EN
  input  logic       read_bit,
`endif
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte,
  output logic       busy,
  output logic       presense
);

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  // Counter values seen on the tick that completes each interval.
  localparam logic [9:0] RSTL_END = 10'(T_RSTL - 1);
  localparam logic [9:0] PDS_END  = 10'(T_PDS - 1);
  localparam logic [9:0] RSTH_END = 10'(T_RSTH - 1);
  localparam logic [9:0] LOW1_END = 10'(T_LOW1 - 1);
  localparam logic [9:0] LOW0_END = 10'(T_LOW0 - 1);
  localparam logic [9:0] RDS_END  = 10'(T_RDS - 1);
  localparam logic [9:0] SLOT_END = 10'(T_SLOT - 1);

  typedef enum logic [1:0] {IDLE, RST_LOW, RST_REL, SLOT} state_t;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_RBIT} op_t;

  state_t               state, state_next;
  op_t                  op, accept_op;
  logic                 accept;
  logic [PRESC_W-1:0]   presc;
  logic [9:0]           us_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           tx_byte;
  logic [7:0]           rx_byte;
  logic [1:0]           sync;
  logic                 pres_sample;
  logic                 drive_low;
  logic                 tick;
  logic                 tx_bit;
  logic [9:0]           low_end;
  logic                 last_slot;
  logic                 slot_end;
  logic                 phase_end;

  // Open-drain: only ever pull low; drive_low is an async-reset flop so rst
  // releases the bus without waiting for a clock edge.
  assign dWire = drive_low ? 1'b0 : 1'bz;

  assign busy      = (state != IDLE);
  assign tick      = busy && (presc == PRESC_MAX);
  // Read slots use the short low pulse, the same as a written 1.
  assign tx_bit    = (op == OP_WRITE) ? tx_byte[bit_cnt] : 1'b1;
  assign low_end   = tx_bit ? LOW1_END : LOW0_END;
  assign last_slot = (bit_cnt == 3'd7) || (op == OP_RBIT);
  assign slot_end  = (state == SLOT) && tick && (us_cnt == SLOT_END);
  assign phase_end = ((state == RST_LOW) && (us_cnt == RSTL_END)) ||
                     ((state == SLOT) && (us_cnt == SLOT_END));

  always_ff @(posedge CLK_10MHZ or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    accept_op  = OP_WRITE;
    case (state)
      IDLE: begin
        if (reset) begin
          state_next = RST_LOW;
          accept     = 1'b1;
        end else if (write_byte) begin
          state_next = SLOT;
          accept     = 1'b1;
          accept_op  = OP_WRITE;
        end else if (read_byte) begin
          state_next = SLOT;
          accept     = 1'b1;
          accept_op  = OP_READ;
        end
`ifdef ONEWIRE_READ_BIT_EN
        else if (read_bit) begin
          state_next = SLOT;
          accept     = 1'b1;
          accept_op  = OP_RBIT;
        end
`endif
      end
      RST_LOW: if (tick && (us_cnt == RSTL_END)) state_next = RST_REL;
      RST_REL: if (tick && (us_cnt == RSTH_END)) state_next = IDLE;
      SLOT:    if (slot_end && last_slot)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_10MHZ or posedge rst) begin
    if (rst) begin
      sync        <= 2'b11;  // idle bus level, avoids a false low after reset
      presc       <= '0;
      us_cnt      <= '0;
      bit_cnt     <= '0;
      op          <= OP_WRITE;
      tx_byte     <= '0;
      rx_byte     <= '0;
      pres_sample <= 1'b0;
      presense    <= 1'b0;
      out_byte    <= '0;
      drive_low   <= 1'b0;
    end else begin
      sync <= {sync[0], dWire};

      // Timebase is held at zero in IDLE, so every operation starts aligned.
      if (state == IDLE) begin
        presc  <= '0;
        us_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) us_cnt <= phase_end ? 10'd0 : us_cnt + 10'd1;
      end

      if (accept) begin
        op        <= accept_op;
        tx_byte   <= in_byte;
        bit_cnt   <= '0;
        drive_low <= 1'b1;
      end

      case (state)
        RST_LOW: if (tick && (us_cnt == RSTL_END)) drive_low <= 1'b0;
        RST_REL: begin
          if (tick && (us_cnt == PDS_END))  pres_sample <= ~sync[1];
          if (tick && (us_cnt == RSTH_END)) presense    <= pres_sample;
        end
        SLOT: begin
          if (tick && (us_cnt == low_end)) drive_low <= 1'b0;
          if (tick && (us_cnt == RDS_END)) rx_byte[bit_cnt] <= sync[1];
          if (slot_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (last_slot) begin
              if (op == OP_READ)      out_byte <= rx_byte;
              else if (op == OP_RBIT) out_byte <= {7'b0, rx_byte[0]};
            end else begin
              drive_low <= 1'b1;  // next slot starts immediately
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
